// File: rtl/clock_pkg.sv
// Shared types and limits for the 12-hour clock setting controller.
// Pure declarations: no latency and no flow control of its own.
// Contents: FSM state enum, field limits, edit_field encodings, preload clamps.
package clock_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HOUR,
      ST_MINUTE,
      ST_AMPM,
      ST_COMMIT
   } state_t;

   localparam int HOUR_MIN = 1;
   localparam int HOUR_MAX = 12;
   localparam int MIN_MAX  = 59;

   // edit_field encodings (display blink select)
   localparam logic [1:0] FIELD_NONE   = 2'd0;
   localparam logic [1:0] FIELD_HOUR   = 2'd1;
   localparam logic [1:0] FIELD_MINUTE = 2'd2;
   localparam logic [1:0] FIELD_AMPM   = 2'd3;

   // Out-of-range hours (0, 13..15) become 12 so editing always starts legal.
   function automatic logic [3:0] clamp_hour(input logic [3:0] h);
      return (h >= 4'(HOUR_MIN) && h <= 4'(HOUR_MAX)) ? h : 4'(HOUR_MAX);
   endfunction

   // Minutes 60..63 become 0.
   function automatic logic [5:0] clamp_minute(input logic [5:0] m);
      return (m > 6'(MIN_MAX)) ? 6'd0 : m;
   endfunction

endpackage

// File: rtl/clock_set_ctrl_field_counter.sv
// Wrapping LO..HI counter with a synchronous load, used for the hour and minute scratch fields.
// Latency: load/increment visible one cycle after the request; load has priority over inc.
// Backpressure: none, every request is accepted in the cycle it is presented.
// Ports: clk, rst_n (async active-low), load/load_val (preload), inc (step, HI wraps to LO), value.
module field_counter #(
   parameter int WIDTH   = 4,
   parameter int LO      = 1,
   parameter int HI      = 12,
   parameter int RST_VAL = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             inc,
   output logic [WIDTH-1:0] value
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= WIDTH'(RST_VAL);
      end else if (load) begin
         value <= load_val;
      end else if (inc) begin
         value <= (value == WIDTH'(HI)) ? WIDTH'(LO) : value + 1'b1;
      end
   end

endmodule

// File: rtl/clock_set_ctrl.sv
// Button-driven hour/minute/AM-PM editor for the time or the alarm, committing on the 4th mode press.
// Latency: set_time pulses (and alarm_* update) in the single COMMIT cycle after the last mode press.
// Backpressure: none; button pulses are one-cycle events, mode beats inc, presses in COMMIT are dropped.
// Ports: clock_sec, reset_n (async active-low); btn_mode/btn_inc/btn_sel; cur_* preload inputs;
//        set_time + set_* to the timekeeper; held alarm_* levels; edit_active/edit_field for display.
// Optional: define SET_TIMEOUT_EN to abandon an edit after TIMEOUT_CYC button-free cycles.
module clock_set_ctrl
   import clock_pkg::*;
#(
   parameter int TIMEOUT_CYC  = 30,
   parameter int RST_ALM_HOUR = 12,
   parameter int RST_ALM_MIN  = 0
) (
   input  logic       clock_sec,
   input  logic       reset_n,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       btn_sel,
   input  logic [3:0] cur_hour,
   input  logic [5:0] cur_minute,
   input  logic       cur_am_pm,
   output logic       set_time,
   output logic [3:0] set_hour,
   output logic [5:0] set_minute,
   output logic       set_am_pm,
   output logic [3:0] alarm_hour,
   output logic [5:0] alarm_minute,
   output logic       alarm_am_pm,
   output logic       edit_active,
   output logic [1:0] edit_field
);

   state_t     state_q, state_d;
   logic       target_q;          // 0 = time, 1 = alarm
   logic       scr_am_pm;
   logic [3:0] scr_hour;
   logic [5:0] scr_minute;
   logic       timeout;

   logic       enter;
   logic       inc_ok;            // increment only when mode is not pressed the same cycle
   logic [3:0] pre_hour;
   logic [5:0] pre_minute;
   logic       pre_am_pm;

   assign enter  = (state_q == ST_IDLE) && btn_mode;
   assign inc_ok = btn_inc && !btn_mode;

   // Preload source follows btn_sel at the entry press.
   assign pre_hour   = clamp_hour(btn_sel ? alarm_hour : cur_hour);
   assign pre_minute = clamp_minute(btn_sel ? alarm_minute : cur_minute);
   assign pre_am_pm  = btn_sel ? alarm_am_pm : cur_am_pm;

   field_counter #(.WIDTH(4), .LO(HOUR_MIN), .HI(HOUR_MAX), .RST_VAL(HOUR_MAX)) u_hour (
      .clk      (clock_sec),
      .rst_n    (reset_n),
      .load     (enter),
      .load_val (pre_hour),
      .inc      (inc_ok && (state_q == ST_HOUR)),
      .value    (scr_hour)
   );

   field_counter #(.WIDTH(6), .LO(0), .HI(MIN_MAX), .RST_VAL(0)) u_minute (
      .clk      (clock_sec),
      .rst_n    (reset_n),
      .load     (enter),
      .load_val (pre_minute),
      .inc      (inc_ok && (state_q == ST_MINUTE)),
      .value    (scr_minute)
   );

`ifdef SET_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] idle_cnt;
   logic          in_edit;

   assign in_edit = (state_q == ST_HOUR) || (state_q == ST_MINUTE) || (state_q == ST_AMPM);
   // Fires on the TIMEOUT_CYC-th consecutive button-free edit cycle.
   assign timeout = in_edit && !btn_mode && !btn_inc && (idle_cnt == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clock_sec or negedge reset_n) begin
      if (!reset_n) begin
         idle_cnt <= '0;
      end else if (!in_edit || btn_mode || btn_inc || timeout) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_cnt + 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clock_sec or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         target_q     <= 1'b0;
         scr_am_pm    <= 1'b0;
         set_time     <= 1'b0;
         set_hour     <= 4'(HOUR_MAX);
         set_minute   <= 6'd0;
         set_am_pm    <= 1'b0;
         alarm_hour   <= 4'(RST_ALM_HOUR);
         alarm_minute <= 6'(RST_ALM_MIN);
         alarm_am_pm  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (enter) begin
            target_q  <= btn_sel;
            scr_am_pm <= pre_am_pm;
         end else if (state_q == ST_AMPM && inc_ok) begin
            scr_am_pm <= ~scr_am_pm;
         end
         // Time commit is registered so the pulse coincides with the COMMIT cycle.
         set_time <= (state_q == ST_AMPM) && btn_mode && !target_q && !timeout;
         if ((state_q == ST_AMPM) && btn_mode && !target_q) begin
            set_hour   <= scr_hour;
            set_minute <= scr_minute;
            set_am_pm  <= scr_am_pm;
         end
         if ((state_q == ST_COMMIT) && target_q) begin
            alarm_hour   <= scr_hour;
            alarm_minute <= scr_minute;
            alarm_am_pm  <= scr_am_pm;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      edit_field = FIELD_NONE;
      unique case (state_q)
         ST_IDLE:   if (btn_mode) state_d = ST_HOUR;
         ST_HOUR:   begin
            edit_field = FIELD_HOUR;
            if (btn_mode) state_d = ST_MINUTE;
         end
         ST_MINUTE: begin
            edit_field = FIELD_MINUTE;
            if (btn_mode) state_d = ST_AMPM;
         end
         ST_AMPM:   begin
            edit_field = FIELD_AMPM;
            if (btn_mode) state_d = ST_COMMIT;
         end
         ST_COMMIT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
      if (timeout) state_d = ST_IDLE;
   end

   assign edit_active = (state_q != ST_IDLE);

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed self-checking bench for clock_set_ctrl: reset, time edit, alarm edit, wraps, clamps, timeout.
// Inputs change 1 time unit after the rising edge; outputs are checked at that point.
// Set_time pulses are counted and captured on the falling edge.
module tb_clock_set_ctrl;

   logic       clock_sec = 1'b0;
   logic       reset_n;
   logic       btn_mode, btn_inc, btn_sel;
   logic [3:0] cur_hour;
   logic [5:0] cur_minute;
   logic       cur_am_pm;
   logic       set_time;
   logic [3:0] set_hour;
   logic [5:0] set_minute;
   logic       set_am_pm;
   logic [3:0] alarm_hour;
   logic [5:0] alarm_minute;
   logic       alarm_am_pm;
   logic       edit_active;
   logic [1:0] edit_field;

   int checks   = 0;
   int failures = 0;
   int pulses   = 0;
   logic [3:0] cap_hour;
   logic [5:0] cap_minute;
   logic       cap_am_pm;

   clock_set_ctrl dut (
      .clock_sec    (clock_sec),
      .reset_n      (reset_n),
      .btn_mode     (btn_mode),
      .btn_inc      (btn_inc),
      .btn_sel      (btn_sel),
      .cur_hour     (cur_hour),
      .cur_minute   (cur_minute),
      .cur_am_pm    (cur_am_pm),
      .set_time     (set_time),
      .set_hour     (set_hour),
      .set_minute   (set_minute),
      .set_am_pm    (set_am_pm),
      .alarm_hour   (alarm_hour),
      .alarm_minute (alarm_minute),
      .alarm_am_pm  (alarm_am_pm),
      .edit_active  (edit_active),
      .edit_field   (edit_field)
   );

   always #5 clock_sec = ~clock_sec;

   always @(negedge clock_sec) begin
      if (set_time === 1'b1) begin
         pulses     = pulses + 1;
         cap_hour   = set_hour;
         cap_minute = set_minute;
         cap_am_pm  = set_am_pm;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         failures = failures + 1;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clock_sec);
         #1;
      end
   endtask

   task automatic press_mode();
      btn_mode = 1'b1; tick(); btn_mode = 1'b0;
   endtask

   task automatic press_inc(input int n);
      for (int i = 0; i < n; i++) begin
         btn_inc = 1'b1; tick(); btn_inc = 1'b0;
      end
   endtask

   task automatic press_both();
      btn_mode = 1'b1; btn_inc = 1'b1; tick(); btn_mode = 1'b0; btn_inc = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; btn_sel = 1'b0;
      cur_hour = 4'd2; cur_minute = 6'd45; cur_am_pm = 1'b1;
      tick(3);
      // Reset state
      chk("rst_set_time", set_time, 0);
      chk("rst_set_hour", set_hour, 12);
      chk("rst_set_minute", set_minute, 0);
      chk("rst_set_am_pm", set_am_pm, 0);
      chk("rst_alarm_hour", alarm_hour, 12);
      chk("rst_alarm_minute", alarm_minute, 0);
      chk("rst_alarm_am_pm", alarm_am_pm, 0);
      chk("rst_edit_active", edit_active, 0);
      chk("rst_edit_field", edit_field, 0);
      reset_n = 1'b1;
      tick(2);

      // T2: time edit from 2:45 PM to 5:50 AM
      btn_sel = 1'b0;
      press_mode();
      chk("t2_field_hour", edit_field, 1);
      chk("t2_active", edit_active, 1);
      press_inc(3);
      press_mode();
      chk("t2_field_minute", edit_field, 2);
      press_inc(5);
      press_mode();
      chk("t2_field_ampm", edit_field, 3);
      press_inc(1);
      press_mode();
      chk("t2_commit_pulse", set_time, 1);
      chk("t2_commit_field", edit_field, 0);
      chk("t2_commit_active", edit_active, 1);
      chk("t2_set_hour", set_hour, 5);
      chk("t2_set_minute", set_minute, 50);
      chk("t2_set_am_pm", set_am_pm, 0);
      tick();
      chk("t2_pulse_ends", set_time, 0);
      chk("t2_idle", edit_active, 0);
      chk("t2_pulse_count", pulses, 1);
      chk("t2_alarm_untouched", alarm_hour, 12);

      // T3: alarm edit 12:00 AM -> 2:50 PM, mode during COMMIT ignored
      btn_sel = 1'b1;
      press_mode();
      press_inc(2);
      press_mode();
      press_inc(50);
      press_mode();
      press_inc(1);
      btn_sel = 1'b0;
      press_mode();
      chk("t3_commit_no_pulse", set_time, 0);
      chk("t3_commit_active", edit_active, 1);
      press_mode();
      chk("t3_mode_in_commit_ignored", edit_active, 0);
      chk("t3_alarm_hour", alarm_hour, 2);
      chk("t3_alarm_minute", alarm_minute, 50);
      chk("t3_alarm_am_pm", alarm_am_pm, 1);
      chk("t3_set_hour_holds", set_hour, 5);
      chk("t3_pulse_count", pulses, 1);

      // T4: wraps and mode+inc collision, via time commit of 12:59 AM edits
      cur_hour = 4'd12; cur_minute = 6'd59; cur_am_pm = 1'b0;
      press_mode();
      press_inc(1);            // 12 -> 1
      press_both();            // advance, hour stays 1
      chk("t4_both_advances", edit_field, 2);
      press_inc(1);            // 59 -> 0
      press_both();            // advance, minute stays 0
      chk("t4_both_advances2", edit_field, 3);
      press_both();            // advance to COMMIT, am_pm not toggled
      chk("t4_commit_pulse", set_time, 1);
      chk("t4_hour_wrap", set_hour, 1);
      chk("t4_minute_wrap", set_minute, 0);
      chk("t4_am_pm", set_am_pm, 0);
      tick();

      // T5: preload clamps
      cur_hour = 4'd0; cur_minute = 6'd63; cur_am_pm = 1'b1;
      press_mode(); press_mode(); press_mode(); press_mode();
      chk("t5_hour_clamp", set_hour, 12);
      chk("t5_minute_clamp", set_minute, 0);
      chk("t5_am_pm", set_am_pm, 1);
      tick();
      chk("t5_pulse_count", pulses, 3);
      chk("t5_cap_hour", cap_hour, 12);

      // T1: reset mid-edit of the alarm
      btn_sel = 1'b1;
      press_mode();
      press_inc(1);
      press_mode();
      #2 reset_n = 1'b0;
      #1;
      chk("t1_rst_active", edit_active, 0);
      chk("t1_rst_field", edit_field, 0);
      chk("t1_rst_alarm_hour", alarm_hour, 12);
      chk("t1_rst_alarm_minute", alarm_minute, 0);
      chk("t1_rst_alarm_am_pm", alarm_am_pm, 0);
      chk("t1_rst_set_hour", set_hour, 12);
      tick(2);
      reset_n = 1'b1;
      tick(2);
      chk("t1_stays_idle", edit_active, 0);
      chk("t1_pulse_count", pulses, 3);

      // T6: idle behaviour in MINUTE
      btn_sel = 1'b0; cur_hour = 4'd2; cur_minute = 6'd45; cur_am_pm = 1'b1;
      press_mode();
      press_mode();
`ifdef SET_TIMEOUT_EN
      tick(29);
      chk("t6_29_still_minute", edit_field, 2);
      press_inc(1);
      tick(29);
      chk("t6_restart_still_minute", edit_field, 2);
      tick(1);
      chk("t6_timeout_idle", edit_active, 0);
      chk("t6_timeout_field", edit_field, 0);
      tick(3);
      chk("t6_no_pulse", pulses, 3);
`else
      tick(40);
      chk("t6_persists", edit_field, 2);
      press_inc(1);             // 45 -> 46
      press_mode();
      press_mode();
      chk("t6_commit_pulse", set_time, 1);
      chk("t6_set_minute", set_minute, 46);
      tick();
      chk("t6_pulse_count", pulses, 4);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
